// File: rtl/truth_table_sweeper_if.sv
// Sweeper handshake/result bundle: start plus the two implementation outputs in,
// stimulus vector, status and registered truth-table results out.
interface truth_table_sweeper_if #(
    parameter int N_INPUTS = 4
);
    logic                     start;
    logic                     s_ref;
    logic                     s_min;
    logic [N_INPUTS-1:0]      abcd;
    logic                     busy;
    logic                     done;
    logic                     equivalent;
    logic [N_INPUTS:0]        mismatch_count;
    logic [N_INPUTS-1:0]      first_mismatch;
    logic [2**N_INPUTS-1:0]   truth_ref;
    logic [2**N_INPUTS-1:0]   truth_min;

    modport master (
        output start, s_ref, s_min,
        input  abcd, busy, done, equivalent, mismatch_count, first_mismatch,
               truth_ref, truth_min
    );

    modport slave (
        input  start, s_ref, s_min,
        output abcd, busy, done, equivalent, mismatch_count, first_mismatch,
               truth_ref, truth_min
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Purpose: sweeps all input vectors over two SOP implementations and compares them; TRUTH_SWEEP_GRAY_ORDER_EN selects Gray sweep order.
// Latency: done rises 2**N_INPUTS*(SETTLE_CYCLES+1) cycles after the start-accepting edge.
// Backpressure: none; start is only honoured in IDLE/DONE and ignored while busy.
module truth_table_sweeper #(
    parameter int N_INPUTS      = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    truth_table_sweeper_if.slave  sw
);
    localparam int                  NVEC      = 2**N_INPUTS;
    localparam logic [N_INPUTS-1:0] LAST_IDX  = N_INPUTS'(NVEC - 1);
    localparam logic [3:0]          SETTLE_LD = 4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [N_INPUTS-1:0] idx;
    logic [N_INPUTS-1:0] idx_inc;
    logic [3:0]          settle_cnt;
    logic                first_seen;
    logic                accept;
    logic                sample;
    logic                mismatch;
    logic [N_INPUTS:0]   count_upd;

    function automatic logic [N_INPUTS-1:0] vec(input logic [N_INPUTS-1:0] i);
`ifdef TRUTH_SWEEP_GRAY_ORDER_EN
        return i ^ (i >> 1);
`else
        return i;
`endif
    endfunction

    assign idx_inc   = idx + 1'b1;
    assign mismatch  = sw.s_ref ^ sw.s_min;
    assign count_upd = sw.mismatch_count + {{N_INPUTS{1'b0}}, mismatch};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        sample    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (sw.start) begin
                    accept    = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                // counter holds the cycles still to wait including this one
                if (settle_cnt <= 4'd1) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                sample    = 1'b1;
                state_nxt = (idx == LAST_IDX) ? DONE : SETTLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx               <= '0;
            settle_cnt        <= '0;
            first_seen        <= 1'b0;
            sw.abcd           <= '0;
            sw.busy           <= 1'b0;
            sw.done           <= 1'b0;
            sw.equivalent     <= 1'b0;
            sw.mismatch_count <= '0;
            sw.first_mismatch <= '0;
            sw.truth_ref      <= '0;
            sw.truth_min      <= '0;
        end else begin
            if (accept) begin
                idx               <= '0;
                settle_cnt        <= SETTLE_LD;
                first_seen        <= 1'b0;
                sw.abcd           <= vec('0);
                sw.busy           <= 1'b1;
                sw.done           <= 1'b0;
                sw.equivalent     <= 1'b0;
                sw.mismatch_count <= '0;
                sw.first_mismatch <= '0;
                sw.truth_ref      <= '0;
                sw.truth_min      <= '0;
            end

            if (state == SETTLE) begin
                settle_cnt <= settle_cnt - 4'd1;
            end

            if (sample) begin
                sw.truth_ref[sw.abcd] <= sw.s_ref;
                sw.truth_min[sw.abcd] <= sw.s_min;
                if (mismatch) begin
                    sw.mismatch_count <= count_upd;
                    if (!first_seen) begin
                        sw.first_mismatch <= sw.abcd;
                        first_seen        <= 1'b1;
                    end
                end
                if (idx == LAST_IDX) begin
                    sw.busy       <= 1'b0;
                    sw.done       <= 1'b1;
                    sw.equivalent <= (count_upd == '0);
                end else begin
                    idx        <= idx_inc;
                    sw.abcd    <= vec(idx_inc);
                    settle_cnt <= SETTLE_LD;
                end
            end
        end
    end
endmodule
